// File: rtl/fpu_div_seq_pkg.sv
// Shared encodings for the sequential FP-side divider.
package fpu_div_seq_pkg;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic DIV_SIGNED   = 1'b0;
  localparam logic DIV_UNSIGNED = 1'b1;
endpackage

// File: rtl/fpu_div_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step
  import fpu_div_seq_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);
  logic [W+1:0] shl, diff;

  always_comb begin
    shl   = {rem_i, bit_i};
    diff  = shl - {2'b00, dvsr_i};
    // a clear sign bit means the trial subtraction did not borrow
    q_o   = ~diff[W+1];
    rem_o = q_o ? diff[W:0] : shl[W:0];
  end
endmodule

// File: rtl/fpu_div_seq.sv
// Iterative radix-2 restoring divider with start/busy/done handshake and signed fix-up.
module fpu_div_seq
  import fpu_div_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             DIVctrl,
  input  logic [0:WIDTH-1] fbusA,
  input  logic [0:WIDTH-1] fbusB,
  output logic [0:WIDTH-1] quotient,
  output logic [0:WIDTH-1] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     prem_q, prem_d;
  logic [WIDTH-1:0]   dq_q, dvsr_q;
  logic [WIDTH-1:0]   a_in, b_in, a_mag, b_mag;
  logic [WIDTH-1:0]   quot_q, rem_q;
  logic               qneg_q, rneg_q, dbz_q;
  logic               busy_q, done_q, dbzo_q;
  logic               is_signed, b_zero, q_bit;

  assign a_in      = fbusA;
  assign b_in      = fbusB;
  assign is_signed = (DIVctrl == DIV_SIGNED);
  assign b_zero    = (b_in == '0);
  assign a_mag     = (is_signed && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag     = (is_signed && b_in[WIDTH-1]) ? -b_in : b_in;

  // dq_q shifts dividend bits out of the MSB while quotient bits enter at the LSB
  div_step #(.W(WIDTH)) u_step (
    .rem_i  (prem_q),
    .bit_i  (dq_q[WIDTH-1]),
    .dvsr_i (dvsr_q),
    .rem_o  (prem_d),
    .q_o    (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dq_q    <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbzo_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          qneg_q  <= is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          rneg_q  <= is_signed & a_in[WIDTH-1];
          dbz_q   <= b_zero;
          // divide-by-zero returns the dividend exactly as presented
          dq_q    <= b_zero ? a_in : a_mag;
          dvsr_q  <= b_mag;
          prem_q  <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= b_zero ? FIX : RUN;
        end
        RUN: begin
          prem_q <= prem_d;
          dq_q   <= {dq_q[WIDTH-2:0], q_bit};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          if (dbz_q) begin
            quot_q <= '1;
            rem_q  <= dq_q;
          end else begin
            quot_q <= qneg_q ? -dq_q : dq_q;
            rem_q  <= rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
          end
          dbzo_q  <= dbz_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbzo_q;
endmodule

// File: tb/tb_fpu_div_seq.sv
// Scoreboard bench for fpu_div_seq: expectations queued at acceptance, checked at done.
module tb_fpu_div_seq;
  localparam int W   = 32;
  localparam int TMO = 60;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset, start, DIVctrl;
  logic [0:W-1]   fbusA, fbusB, quotient, remainder;
  logic           busy, done, div_by_zero;

  exp_t           sb[$];
  int             total = 0;
  int             bad   = 0;
  logic [W-1:0]   last_q, last_r;

  always #5 clk = ~clk;

  fpu_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .DIVctrl(DIVctrl),
    .fbusA(fbusA), .fbusB(fbusB), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  function automatic exp_t mk(logic [W-1:0] q, logic [W-1:0] r, logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    return e;
  endfunction

  // Reference via magnitudes and native / and %, then sign fix-up
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic uns);
    logic [W-1:0] ma, mb, q, r;
    if (b == '0) return mk('1, a, 1'b1);
    ma = (!uns && a[W-1]) ? -a : a;
    mb = (!uns && b[W-1]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (!uns && (a[W-1] ^ b[W-1])) q = -q;
    if (!uns && a[W-1]) r = -r;
    return mk(q, r, 1'b0);
  endfunction

  // Drive a start pulse with the DUT idle; leaves time at #1 after the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns, input exp_t e);
    start = 1'b1; DIVctrl = uns; fbusA = a; fbusB = b;
    @(posedge clk);
    sb.push_back(e);
    #1;
    start = 1'b0; DIVctrl = $urandom_range(0, 1); fbusA = $urandom; fbusB = $urandom;
  endtask

  // Edges counted from acceptance until done is seen; -1 when the bound expires
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; DIVctrl = 1'b0; fbusA = '0; fbusB = '0;
    @(posedge clk); #1;
    total++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      bad++; $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b want all 0",
                      quotient, remainder, busy, done, div_by_zero);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; exp_t e;
    issue(32'd100, 32'd7, 1'b1, mk(32'd14, 32'd2, 1'b0));
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL uns_busy_start: got %b want 1", busy); end
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 33) begin bad++; $display("FAIL uns_latency: got %0d want 33", lat); end
    total++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      bad++; $display("FAIL uns_result: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                      quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL uns_busy_done: got %b want 0", busy); end
    last_q = e.q; last_r = e.r;
  endtask

  task automatic test_signed_and_bounds();
    logic [W-1:0] ta[5] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] tb[5] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
    logic         tu[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] tq[5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd1, 32'h80000000};
    logic [W-1:0] tr[5] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0};
    int lat; exp_t e; logic [W-1:0] a, b; logic u;
    for (int i = 0; i < 13; i++) begin
      if (i < 5) begin
        a = ta[i]; b = tb[i]; u = tu[i];
        issue(a, b, u, mk(tq[i], tr[i], 1'b0));
      end else begin
        a = $urandom; b = $urandom >> $urandom_range(0, 31); u = $urandom_range(0, 1);
        issue(a, b, u, model(a, b, u));
      end
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if (lat !== (e.dbz ? 1 : 33)) begin bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, e.dbz ? 1 : 33); end
      total++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        bad++; $display("FAIL div_result[%0d] a=%h b=%h u=%b: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                        i, a, b, u, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      last_q = e.q; last_r = e.r;
    end
  endtask

  task automatic test_div_zero();
    int lat; exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue(32'h12345678, 32'd0, 1'b1, mk('1, 32'h12345678, 1'b1));
      else        issue(32'hF0000001, 32'd0, 1'b0, mk('1, 32'hF0000001, 1'b1));
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if (lat !== 1) begin bad++; $display("FAIL dbz_latency[%0d]: got %0d want 1", i, lat); end
      total++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        bad++; $display("FAIL dbz_result[%0d]: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                        i, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      last_q = e.q; last_r = e.r;
    end
  endtask

  task automatic test_start_ignored();
    int lat, extra; exp_t e;
    issue(32'd1000, 32'd3, 1'b1, mk(32'd333, 32'd1, 1'b0));
    lat = -1;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk); #1;
      start = (k == 4 || k == 19);
      if (start) begin fbusA = 32'd5; fbusB = 32'd1; DIVctrl = 1'b1; end
      if (k == 10) begin
        total++;
        if ({quotient, remainder} !== {last_q, last_r}) begin
          bad++; $display("FAIL hold_outputs: got q=%h r=%h want q=%h r=%h", quotient, remainder, last_q, last_r);
        end
      end
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if (lat !== 33) begin bad++; $display("FAIL ign_latency: got %0d want 33", lat); end
    total++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      bad++; $display("FAIL ign_result: got q=%h r=%h want q=%h r=%h", quotient, remainder, e.q, e.r);
    end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
    last_q = e.q; last_r = e.r;
  endtask

  task automatic test_back_to_back();
    int lat; exp_t e;
    start = 1'b1; DIVctrl = 1'b1; fbusA = 32'd50; fbusB = 32'd5;
    @(posedge clk);
    sb.push_back(mk(32'd10, 32'd0, 1'b0));
    #1;
    fbusA = 32'hFFFFFFB2; fbusB = 32'd7; DIVctrl = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if (lat !== 33) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 33", n, lat); end
      total++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        bad++; $display("FAIL b2b_result[%0d]: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                        n, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      if (n == 0) begin
        @(posedge clk);
        sb.push_back(mk(32'hFFFFFFF5, 32'hFFFFFFFF, 1'b0));
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
      end
      last_q = e.q; last_r = e.r;
    end
  endtask

  task automatic test_reset_mid();
    int lat; exp_t e;
    issue(32'd12345, 32'd17, 1'b1, mk(32'd726, 32'd3, 1'b0));
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    void'(sb.pop_front());
    total++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      bad++; $display("FAIL mid_reset: got q=%h r=%h busy=%b done=%b dbz=%b want all 0",
                      quotient, remainder, busy, done, div_by_zero);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    issue(32'd1000, 32'd10, 1'b1, mk(32'd100, 32'd0, 1'b0));
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 33) begin bad++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
    total++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      bad++; $display("FAIL post_reset_result: got q=%h r=%h want q=%h r=%h", quotient, remainder, e.q, e.r);
    end
  endtask

  initial begin
    last_q = '0; last_r = '0;
    test_reset();
    test_unsigned();
    test_signed_and_bounds();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
